// File: rtl/wave_table_loader.sv
// Streams one waveform table from a valid/ready byte source into
// the generator's sample memory write port, with a checksum and a stall timeout.
module wave_table_loader #(
  parameter int          TABLE_LEN = 1000,
  parameter logic [15:0] SINE_BASE = 16'h0000,
  parameter logic [15:0] TRI_BASE  = 16'h03E8,
  parameter int          TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  table_sel,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  localparam logic [15:0] LAST = 16'(TABLE_LEN - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] base;
  logic [15:0] count;
  logic [15:0] idle_cnt;
  logic        go;
  logic        bad;
  logic        hs;
  logic        last;
  logic        tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = LOAD;
      LOAD: begin
        if (last) state_nx = DONE;
        else if (tmo) state_nx = IDLE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-cycle events; s_ready is only ever high in LOAD.
  always_comb begin
    busy = (state != IDLE);
    go   = 1'b0;
    bad  = 1'b0;
    hs   = 1'b0;
    last = 1'b0;
    tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        go  = start && !table_sel[1];
        bad = start && table_sel[1];
      end
      LOAD: begin
        hs   = s_valid && s_ready;
        last = hs && (count == LAST);
        tmo  = !hs && (idle_cnt == TMO_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready  <= 1'b0;
      mem_addr <= 16'h0000;
      mem_din  <= 8'h00;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= 16'h0000;
      base     <= 16'h0000;
      count    <= 16'h0000;
      idle_cnt <= 16'h0000;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (go) begin
        base     <= table_sel[0] ? TRI_BASE : SINE_BASE;
        count    <= 16'h0000;
        idle_cnt <= 16'h0000;
        checksum <= 16'h0000;
        error    <= 1'b0;
        s_ready  <= 1'b1;
      end
      if (bad) error <= 1'b1;
      if (hs) begin
        mem_we   <= 1'b1;
        mem_addr <= base + count;
        mem_din  <= s_data;
        checksum <= checksum + {8'h00, s_data};
        count    <= count + 16'd1;
        idle_cnt <= 16'h0000;
      end else if (state == LOAD) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (last) begin
        s_ready <= 1'b0;
        done    <= 1'b1;
      end
      if (tmo) begin
        s_ready <= 1'b0;
        error   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_table_loader.sv
// Bench for wave_table_loader: transaction model, per-cycle compare,
// and directed loads with literal expectations.
module tb_wave_table_loader;

  localparam int LEN = 1000;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  table_sel = 2'd0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  wave_table_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .table_sel(table_sel), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Transaction-level model of one load.
  int m_pos = 0, m_base = 0, m_quiet = 0;
  int m_sum = 0, m_addr = 0, m_din = 0;
  bit m_load = 0, m_fin = 0, m_err = 0;
  bit m_we = 0, m_done = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0; m_base = 0; m_quiet = 0;
      m_sum = 0; m_addr = 0; m_din = 0;
      m_load = 0; m_fin = 0; m_err = 0;
      m_we = 0; m_done = 0;
    end else begin
      m_we = 0;
      m_done = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_load) begin
        if (s_valid) begin
          m_we = 1;
          m_addr = m_base + m_pos;
          m_din = int'(s_data);
          m_sum = (m_sum + int'(s_data)) % 65536;
          m_pos++;
          m_quiet = 0;
          if (m_pos == LEN) begin
            m_load = 0; m_fin = 1; m_done = 1;
          end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_load = 0; m_err = 1;
          end
        end
      end else if (start) begin
        if (table_sel > 2'd1) begin
          m_err = 1;
        end else begin
          m_load = 1;
          m_base = (table_sel == 2'd1) ? 1000 : 0;
          m_pos = 0; m_quiet = 0; m_sum = 0; m_err = 0;
        end
      end
    end
  end

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  logic [7:0] mem [0:2047];
  int writes = 0, dones = 0;
  int first_addr = -1, max_addr = 0;

  initial forever begin
    @(negedge clk);
    chk("s_ready", 16'(s_ready), 16'(m_load));
    chk("busy", 16'(busy), 16'(m_load || m_fin));
    chk("mem_we", 16'(mem_we), 16'(m_we));
    chk("done", 16'(done), 16'(m_done));
    chk("error", 16'(error), 16'(m_err));
    chk("checksum", checksum, 16'(m_sum));
    if (m_we) begin
      chk("mem_addr", mem_addr, 16'(m_addr));
      chk("mem_din", 16'(mem_din), 16'(m_din));
    end
    if (mem_we) begin
      mem[mem_addr[10:0]] = mem_din;
      writes++;
      if (writes == 1) first_addr = int'(mem_addr);
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end
    if (done) dones++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(int p, int i);
    if (p == 0) return 8'(i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic clear_stats();
    writes = 0; dones = 0; first_addr = -1; max_addr = 0;
  endtask

  task automatic kick(logic [1:0] sel);
    step();
    start = 1'b1;
    table_sel = sel;
    step();
    start = 1'b0;
  endtask

  // Offers n bytes; returns one cycle after the final handshake.
  task automatic push(int n, int p, bit gaps, int start_at);
    int idx = 0;
    int guard = 0;
    int run = 0;
    while (idx < n && guard < 20000) begin
      start = (idx == start_at) && (run == 0);
      if (start) table_sel = 2'd1;
      if (gaps && run < 8 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        run++;
      end else begin
        s_valid = 1'b1;
        run = 0;
      end
      s_data = pat(p, idx);
      if (s_valid && s_ready) idx++;
      guard++;
      step();
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("push_guard", 16'(idx), 16'(n));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_wait", 16'(busy), 16'd0);
  endtask

  initial begin
    int bad;
    int sum;
    step();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_sum", checksum, 16'h0000);
    chk("rst_err", 16'(error), 16'd0);
    rst_n = 1'b1;

    // Sine table, continuous stream.
    clear_stats();
    kick(2'd0);
    push(LEN, 0, 1'b0, -1);
    s_valid = 1'b1;
    chk("last_done", 16'(done), 16'd1);
    chk("last_we", 16'(mem_we), 16'd1);
    chk("last_addr", mem_addr, 16'h03E7);
    chk("last_ready", 16'(s_ready), 16'd0);
    chk("last_busy", 16'(busy), 16'd1);
    step();
    chk("end_busy", 16'(busy), 16'd0);
    s_valid = 1'b0;
    chk("sine_sum", checksum, 16'hE72C);
    chk("sine_writes", 16'(writes), 16'd1000);
    chk("sine_dones", 16'(dones), 16'd1);
    chk("sine_first", 16'(first_addr), 16'h0000);
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (mem[i] !== 8'(i)) bad++;
    chk("sine_mem", 16'(bad), 16'd0);

    // Sine load with a start/triangle pulse mid-stream.
    clear_stats();
    kick(2'd0);
    push(LEN, 1, 1'b0, 300);
    wait_idle();
    chk("busy_writes", 16'(writes), 16'd1000);
    chk("busy_dones", 16'(dones), 16'd1);
    chk("busy_max", 16'(max_addr), 16'h03E7);

    // Triangle table with stalls shorter than the timeout.
    clear_stats();
    kick(2'd1);
    push(LEN, 1, 1'b1, -1);
    wait_idle();
    sum = 0;
    bad = 0;
    for (int i = 0; i < LEN; i++) begin
      sum += int'(pat(1, i));
      if (mem[1000 + i] !== pat(1, i)) bad++;
    end
    chk("tri_mem", 16'(bad), 16'd0);
    chk("tri_sum", checksum, 16'(sum));
    chk("tri_writes", 16'(writes), 16'd1000);
    chk("tri_dones", 16'(dones), 16'd1);
    chk("tri_first", 16'(first_addr), 16'h03E8);
    chk("tri_max", 16'(max_addr), 16'h07CF);

    // Invalid select, then a valid start clears error.
    clear_stats();
    kick(2'd3);
    chk("inv_err", 16'(error), 16'd1);
    chk("inv_busy", 16'(busy), 16'd0);
    step();
    step();
    chk("inv_writes", 16'(writes), 16'd0);
    kick(2'd0);
    chk("clr_err", 16'(error), 16'd0);
    chk("clr_busy", 16'(busy), 16'd1);

    // Stall after 10 bytes until the timeout fires.
    push(10, 0, 1'b0, -1);
    for (int i = 0; i < TMO - 1; i++) step();
    chk("tmo_pre_busy", 16'(busy), 16'd1);
    chk("tmo_pre_err", 16'(error), 16'd0);
    step();
    chk("tmo_busy", 16'(busy), 16'd0);
    chk("tmo_err", 16'(error), 16'd1);
    chk("tmo_dones", 16'(dones), 16'd0);
    chk("tmo_sum", checksum, 16'h002D);

    // Reset in the middle of a sine load.
    kick(2'd0);
    push(501, 0, 1'b0, -1);
    step();
    rst_n = 1'b0;
    step();
    step();
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_ready", 16'(s_ready), 16'd0);
    chk("mid_we", 16'(mem_we), 16'd0);
    chk("mid_sum", checksum, 16'h0000);
    chk("mid_addr", mem_addr, 16'h0000);
    chk("mid_din", 16'(mem_din), 16'd0);
    rst_n = 1'b1;
    clear_stats();
    kick(2'd0);
    push(3, 1, 1'b0, -1);
    chk("re_first", 16'(first_addr), 16'h0000);
    chk("re_writes", 16'(writes), 16'd3);
    for (int i = 0; i < TMO + 2; i++) step();
    chk("re_busy", 16'(busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_table_loader.md
# wave_table_loader

Writes a complete waveform lookup table into the sample memory that the function generator reads, one table per load. Bytes arrive on a valid/ready byte stream from the host-side interface. Each byte is written to the selected table region (sine or triangle) at consecutive addresses. The block reports completion, a 16-bit additive checksum, and errors (bad table select, stream stall timeout). It drives the memory's write port; the generator keeps the read port.

## Interface
- TABLE_LEN, 1000: bytes per table.
- SINE_BASE, 16'h0000: first address of the sine table.
- TRI_BASE, 16'h03E8: first address of the triangle table.
- TIMEOUT, 65535: LOAD-state cycles without a handshake before the load is aborted.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a load; sampled only in IDLE.
- table_sel  in  2  0 = sine, 1 = triangle, 2 and 3 are invalid.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  the block accepts a byte; registered.
- mem_addr  out  16  write address; registered.
- mem_din  out  8  write data; registered.
- mem_we  out  1  write strobe, one cycle per byte; registered.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky; cleared by the next accepted valid start.
- checksum  out  16  sum of the accepted bytes, modulo 2^16.

## Operation
- **Reset values:** state IDLE; s_ready, mem_we, done, error = 0; mem_addr, mem_din, checksum = 0. Internal byte count and idle counter = 0.
- **States:** IDLE, LOAD, DONE.
- **IDLE, start=1, table_sel<=1:**
  - Latch base = SINE_BASE or TRI_BASE.
  - Clear the byte count, idle counter, checksum and error.
  - Set s_ready<=1 and go to LOAD.
- **IDLE, start=1, table_sel>=2:** set error<=1, stay in IDLE, do not touch memory.
- **LOAD, handshake (s_valid && s_ready):**
  - mem_we<=1, mem_addr<=base+count, mem_din<=s_data.
  - checksum<=checksum+s_data, with the 16-bit sum wrapping.
  - count<=count+1; idle counter<=0.
- **LOAD, no handshake:** mem_we<=0; idle counter increments.
- **Last byte (handshake with count==TABLE_LEN-1):** s_ready<=0, done<=1, go to DONE.
- **Timeout (idle counter reaches TIMEOUT-1 with no handshake):** s_ready<=0, error<=1, go to IDLE, no done pulse.
- **DONE:** mem_we<=0, done<=0, go to IDLE.
- **start outside IDLE:** ignored; table_sel is ignored outside IDLE.
- **Address range:** addresses never leave [base, base+TABLE_LEN-1]. Count is 16 bits wide.
- **checksum hold:** the value is held after done or timeout until the next accepted start.
- **Reset mid-load:** all outputs return to their reset values immediately. Bytes already written stay in memory; no rollback is performed.

## Timing
- start accepted at cycle N: busy=1 and s_ready=1 from cycle N+1.
- Handshake at cycle K: mem_we/mem_addr/mem_din valid at K+1. Write latency is 1 cycle.
- Final handshake at K:
  - At K+1: mem_we=1 (final write), done=1, s_ready=0, busy=1.
  - At K+2: busy=0.
- Throughput is 1 byte per cycle with s_valid held high. A full table takes TABLE_LEN+2 cycles from start to busy=0.
- Invalid table_sel at cycle N: error=1 at N+1; busy stays 0.
- Timeout: error=1 and busy=0 exactly TIMEOUT cycles after the last handshake, or after entry to LOAD if no byte has arrived.
- s_ready=0 in IDLE and DONE. The upstream source may hold s_valid high across these states; no byte is consumed.

## Test plan
- **Sine load:** start with table_sel=0 and 1000 bytes of i mod 256, s_valid continuous. Required: writes to addresses 0x0000..0x03E7 with data i mod 256; exactly 1000 mem_we pulses; done pulse one cycle after the last handshake; checksum=0xE72C.
- **Triangle load with gaps:** table_sel=1, random s_valid gaps shorter than TIMEOUT. Required: addresses 0x03E8..0x07CF in order; no duplicate or dropped bytes; single done pulse.
- **Invalid select:** start with table_sel=3. Required: error=1 next cycle, busy=0, mem_we never asserted. A following valid start clears error.
- **Timeout (TIMEOUT=16):** after 10 bytes, drop s_valid. Required: error=1 and busy=0 16 cycles after the 10th handshake; no done pulse; checksum equals the sum of the 10 bytes.
- **Reset mid-load:** assert rst_n=0 after byte 500. Required: all outputs at reset values while rst_n is low. A new load afterwards starts again at the base address.
- **start during busy:** pulse start with table_sel=1 mid-sine-load. Required: ignored; the load continues at sine addresses; one done pulse only.
